clk_step_ctrl: RTL

//  Run/halt/single-step controller for the single-cycle CPU clock derived from sysclk.

---
 rtl/clk_ctrl_pkg.sv | 18 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/clk_step_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared encodings for the CPU clock run/halt/step controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package clk_ctrl_pkg;

  // Operator mode request; 2'b11 is an alias for halt.
  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_HALT = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  // Controller state, exported on the state port.
  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Step button conditioner: 2-flop synchronizer, stability filter, rising-edge pulse.
// Latency: press pulse 2 + DEB_CYC sysclk cycles after the raw level settles high.
// Backpressure: none; the pulse lasts one cycle and is lost if not consumed.
// Ports:
//   sysclk  in   system clock
//   reset   in   asynchronous active-low reset
//   btn     in   raw asynchronous button level
//   press   out  one-cycle pulse on a 0->1 edge of the accepted level
module btn_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic sysclk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int DW = $clog2(DEB_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [DW-1:0] cnt;

  // cnt counts consecutive synchronized samples that differ from the accepted
  // level; the input is a single bit, so those samples are all equal. Any
  // sample matching the accepted level restarts the run.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYC - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step generator for the CPU clock derived from sysclk.
// Latency: run starts one cycle after mode=RUN, first rise div_act cycles later.
// Backpressure: none; presses outside HALT with mode=STEP are discarded.
// Ports:
//   sysclk     in   system clock
//   reset      in   asynchronous active-low reset
//   mode       in   00 run, 01 halt, 10 step, 11 halt
//   div        in   half-period length in sysclk cycles (0 acts as 1)
//   div_load   in   strobe capturing div as the pending divisor
//   step_btn   in   raw step button
//   clk        out  CPU clock
//   clk_rise   out  one-cycle pulse in the first high cycle of clk
//   cycle_cnt  out  clk rising edges since reset
//   state      out  00 halt, 01 run, 10 step
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W   = 27,
  parameter int DEF_DIV = 2,
  parameter int DEB_CYC = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] div,
  input  logic             div_load,
  input  logic             step_btn,
  output logic             clk,
  output logic             clk_rise,
  output logic [31:0]      cycle_cnt,
  output logic [1:0]       state
);

  state_e           st, st_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic [CNT_W-1:0] div_act, div_pend, div_eff;
  logic             clk_nxt, rise_nxt, act_ld;
  logic             tc, press;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .sysclk (sysclk),
    .reset  (reset),
    .btn    (step_btn),
    .press  (press)
  );

  assign div_eff = (div_act == '0) ? CNT_W'(1) : div_act;
  assign tc      = (hcnt == div_eff - CNT_W'(1));
  assign state   = st;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) st <= ST_HALT;
    else        st <= st_nxt;
  end

  // Leaving RUN or STEP only happens at the end of a low phase, so the CPU
  // never sees a shortened high phase.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_HALT: begin
        case (mode)
          MODE_RUN:  st_nxt = ST_RUN;
          MODE_STEP: if (press) st_nxt = ST_STEP;
          MODE_HALT: st_nxt = ST_HALT;
          default:   st_nxt = ST_HALT;
        endcase
      end
      ST_RUN:  if (tc && !clk && mode != MODE_RUN) st_nxt = ST_HALT;
      ST_STEP: if (tc && !clk) st_nxt = ST_HALT;
      default: st_nxt = ST_HALT;
    endcase
  end

  // A step begins with its high phase straight out of HALT. While generating,
  // a low-phase terminal count becomes a rise only if the state is not
  // leaving for HALT. The active divisor is refreshed at falling boundaries
  // and continuously in HALT, so a half-period never mixes two divisors.
  always_comb begin
    clk_nxt  = clk;
    rise_nxt = 1'b0;
    act_ld   = 1'b0;
    hcnt_nxt = tc ? '0 : hcnt + CNT_W'(1);
    if (st == ST_HALT) begin
      clk_nxt  = 1'b0;
      hcnt_nxt = '0;
      act_ld   = 1'b1;
      if (st_nxt == ST_STEP) begin
        clk_nxt  = 1'b1;
        rise_nxt = 1'b1;
      end
    end else if (tc) begin
      if (clk) begin
        clk_nxt = 1'b0;
        act_ld  = 1'b1;
      end else if (st_nxt == st) begin
        clk_nxt  = 1'b1;
        rise_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      clk       <= 1'b0;
      clk_rise  <= 1'b0;
      hcnt      <= '0;
      div_act   <= CNT_W'(DEF_DIV);
      div_pend  <= CNT_W'(DEF_DIV);
      cycle_cnt <= '0;
    end else begin
      clk      <= clk_nxt;
      clk_rise <= rise_nxt;
      hcnt     <= hcnt_nxt;
      if (div_load) div_pend <= div;
      if (act_ld)   div_act  <= div_pend;
      if (rise_nxt) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

endmodule
